bf2ii_stage: RTL

Radix-2² single-path delay-feedback (R22SDF) butterfly type-II stage with an integrated control counter. It sits directly downstream of the type-I butterfly and consumes its serial complex output stream. It applies the trivial −j rotation in the last quarter of each 4·L-sample group, then performs the add/sub butterfly with an L-deep feedback delay. The stage generates its own sel/t controls, output valid and output start-of-frame, so the next twiddle multiplier needs no external sequencing.

---
 rtl/bf2ii_stage.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bf2ii_stage.sv
// Radix-2^2 SDF type-II butterfly stage with built-in sel/t, valid and sof sequencing.
// Optional build macro BF2II_SCALE_EN: butterfly sum/difference halved with round-half-up.
module bf2ii_stage #(
  parameter int data_resolution = 16,
  parameter int delay_num       = 1,
  parameter int ff_out_en       = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic                       dout_valid,
  output logic                       dout_sof,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i
);

  localparam int N  = data_resolution;
  localparam int LW = $clog2(delay_num);
  localparam int CW = $clog2(4 * delay_num);

  logic          advance, filled, sel, t;
  logic [CW-1:0] cnt, cidx, fill_cnt;
  logic [N-1:0]  x_r, x_i, d_r, d_i;
  logic [N-1:0]  bf_r, bf_i, dl_in_r, dl_in_i;
  logic          out_valid, out_sof;
  logic [N-1:0]  dl_r [delay_num];
  logic [N-1:0]  dl_i [delay_num];

  function automatic logic [N-1:0] bf_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic sub);
`ifdef BF2II_SCALE_EN
    logic [N:0] v;
    v = sub ? ({a[N-1], a} - {b[N-1], b}) : ({a[N-1], a} + {b[N-1], b});
    v = v + (N+1)'(1);
    return v[N:1];
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  always_comb begin
    advance = sys_en & din_valid;
    // a frame start overrides the running count and restarts the sel/t sequence
    cidx    = din_sof ? '0 : cnt;
    sel     = cidx[LW];
    t       = cidx[LW+1];
    if (sel & t) begin
      x_r = din_i;
      x_i = -din_r;
    end else begin
      x_r = din_r;
      x_i = din_i;
    end
    d_r = dl_r[delay_num-1];
    d_i = dl_i[delay_num-1];
    if (sel) begin
      bf_r    = bf_op(d_r, x_r, 1'b0);
      bf_i    = bf_op(d_i, x_i, 1'b0);
      dl_in_r = bf_op(d_r, x_r, 1'b1);
      dl_in_i = bf_op(d_i, x_i, 1'b1);
    end else begin
      bf_r    = d_r;
      bf_i    = d_i;
      dl_in_r = x_r;
      dl_in_i = x_i;
    end
    out_valid = advance & filled;
    out_sof   = out_valid & (cidx == CW'(delay_num));
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      cnt      <= '0;
      fill_cnt <= '0;
      filled   <= 1'b0;
      for (int k = 0; k < delay_num; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else if (advance) begin
      cnt <= cidx + CW'(1);
      if (!filled) begin
        fill_cnt <= fill_cnt + CW'(1);
        if (fill_cnt == CW'(delay_num - 1)) filled <= 1'b1;
      end
      dl_r[0] <= dl_in_r;
      dl_i[0] <= dl_in_i;
      for (int k = 1; k < delay_num; k++) begin
        dl_r[k] <= dl_r[k-1];
        dl_i[k] <= dl_i[k-1];
      end
    end
  end

  generate
    if (ff_out_en != 0) begin : g_ff_out
      always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
          dout_valid <= 1'b0;
          dout_sof   <= 1'b0;
          dout_r     <= '0;
          dout_i     <= '0;
        end else if (sys_en) begin
          dout_valid <= out_valid;
          dout_sof   <= out_sof;
          dout_r     <= bf_r;
          dout_i     <= bf_i;
        end
      end
    end else begin : g_comb_out
      assign dout_valid = out_valid;
      assign dout_sof   = out_sof;
      assign dout_r     = bf_r;
      assign dout_i     = bf_i;
    end
  endgenerate

endmodule
